// File: rtl/riscboy_ppu_pkg.sv
// Shared encodings and helpers for the PPU fetch-bus responder.
// Size codes, FSM state type, and the lane-replication and legality functions.
package riscboy_ppu_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Byte and halfword reads are broadcast on every lane so a client can take
  // any lane without re-aligning the data itself.
  function automatic logic [31:0] lane_replicate(input logic [31:0] rdata,
                                                 input logic [1:0]  size,
                                                 input logic [1:0]  a);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{a, 3'b000} +: 8];
    h = rdata[{a[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: return {4{b}};
      SIZE_HALF: return {2{h}};
      default:   return rdata;
    endcase
  endfunction

  function automatic logic req_legal(input logic [1:0] size, input logic [1:0] a);
    case (size)
      SIZE_BYTE: return 1'b1;
      SIZE_HALF: return ~a[0];
      SIZE_WORD: return (a == 2'b00);
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscboy_rr_arbiter.sv
// Round-robin arbiter: grants the first requester above the last winner,
// wrapping; the pointer only moves when the owner strobes advance_i.
module riscboy_rr_arbiter #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          valid_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          found;
  int            idx;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int i = 1; i <= N; i++) begin
      idx = int'(ptr_q) + i;
      if (idx >= N) idx = idx - N;
      if (!found && req_i[IW'(idx)]) begin
        found                 = 1'b1;
        grant_o[IW'(idx)]     = 1'b1;
        grant_idx_o           = IW'(idx);
      end
    end
  end

  assign valid_o = found;
  assign ptr_d   = (advance_i && found) ? grant_idx_o : ptr_q;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= IW'(N - 1);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/riscboy_ppu_mem_responder.sv
// PPU fetch-bus responder: arbitrates clients, reads one SRAM word per request
// and returns lane-replicated data with a one-cycle rdy strobe.
//
// state   | meaning
// IDLE    | waiting for a request; arbitrate and latch the winner
// ISSUE   | mem_ren held high until the SRAM grants it
// CAPTURE | SRAM data on mem_rdata; replicate into req_data
// RESP    | response ready; rdy to the winner is registered on leaving
module riscboy_ppu_mem_responder
  import riscboy_ppu_pkg::*;
#(
  parameter int N_CLIENTS  = 2,
  parameter int W_ADDR     = 32,
  parameter int W_DATA     = 32,
  parameter int W_MEM_ADDR = 14
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_CLIENTS-1:0]          req_vld,
  input  logic [N_CLIENTS*W_ADDR-1:0]   req_addr,
  input  logic [N_CLIENTS*2-1:0]        req_size,
  output logic [N_CLIENTS-1:0]          req_rdy,
  output logic [W_DATA-1:0]             req_data,
  output logic                          mem_ren,
  output logic [W_MEM_ADDR-1:0]         mem_addr,
  input  logic                          mem_gnt,
  input  logic [W_DATA-1:0]             mem_rdata,
  output logic                          busy,
  output logic                          err
);

  localparam int IW = (N_CLIENTS > 1) ? $clog2(N_CLIENTS) : 1;

  state_t                  state_q;
  logic [IW-1:0]           g_q;
  logic [1:0]              a_q;
  logic [1:0]              size_q;
  logic [N_CLIENTS-1:0]    req_rdy_q;
  logic [W_DATA-1:0]       req_data_q;
  logic                    mem_ren_q;
  logic [W_MEM_ADDR-1:0]   mem_addr_q;
  logic                    err_q;

  logic [N_CLIENTS-1:0]    req_avail;
  logic [N_CLIENTS-1:0]    gnt_onehot;
  logic [IW-1:0]           gnt_idx;
  logic                    gnt_valid;
  logic                    arb_advance;
  logic [W_ADDR-1:0]       sel_addr;
  logic [1:0]              sel_size;
  logic                    unused_addr_hi;

  // The client being strobed this cycle still shows its old request; keep it
  // out of arbitration so it is not served twice.
  assign req_avail   = req_vld & ~req_rdy_q;
  assign arb_advance = (state_q == ST_IDLE) && gnt_valid;

  riscboy_rr_arbiter #(.N(N_CLIENTS)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_avail),
    .advance_i   (arb_advance),
    .grant_o     (gnt_onehot),
    .grant_idx_o (gnt_idx),
    .valid_o     (gnt_valid)
  );

  always_comb begin
    sel_addr = '0;
    sel_size = '0;
    for (int k = 0; k < N_CLIENTS; k++) begin
      if (gnt_onehot[k]) begin
        sel_addr = req_addr[k*W_ADDR +: W_ADDR];
        sel_size = req_size[2*k +: 2];
      end
    end
  end

  assign unused_addr_hi = ^sel_addr[W_ADDR-1:W_MEM_ADDR+2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      g_q        <= '0;
      a_q        <= '0;
      size_q     <= '0;
      req_rdy_q  <= '0;
      req_data_q <= '0;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
      err_q      <= 1'b0;
    end else begin
      req_rdy_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            g_q    <= gnt_idx;
            a_q    <= sel_addr[1:0];
            size_q <= sel_size;
            if (req_legal(sel_size, sel_addr[1:0])) begin
              mem_addr_q <= sel_addr[W_MEM_ADDR+1:2];
              mem_ren_q  <= 1'b1;
              state_q    <= ST_ISSUE;
            end else begin
              req_data_q <= '0;
              err_q      <= 1'b1;
              state_q    <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          if (mem_gnt) begin
            mem_ren_q <= 1'b0;
            state_q   <= ST_CAPTURE;
          end else if (!req_vld[g_q]) begin
            mem_ren_q <= 1'b0;
            state_q   <= ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (!req_vld[g_q]) begin
            state_q <= ST_IDLE;
          end else begin
            req_data_q <= lane_replicate(mem_rdata, size_q, a_q);
            state_q    <= ST_RESP;
          end
        end
        ST_RESP: begin
          req_rdy_q[g_q] <= 1'b1;
          state_q        <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_rdy  = req_rdy_q;
  assign req_data = req_data_q;
  assign mem_ren  = mem_ren_q;
  assign mem_addr = mem_addr_q;
  assign busy     = (state_q != ST_IDLE);
  assign err      = err_q;

endmodule

// File: doc/riscboy_ppu_mem_responder.md
Name: riscboy_ppu_mem_responder

Overview:
Responder end of the PPU fetch bus (vld/addr/size/rdy/data) used by the background and sprite pipelines. It arbitrates round-robin among N_CLIENTS initiators and performs each read on a 32-bit synchronous-SRAM port that may be shared with other masters. It returns the read data lane-replicated by transfer size and pulses rdy to the winning client for one cycle. It sits between the PPU fetch units and the video RAM arbiter.

Parameters:
N_CLIENTS, 2, number of fetch initiators; index 0 is the background, index 1 is the sprites.
W_ADDR, 32, client byte-address width.
W_DATA, 32, data width; only 32 is supported.
W_MEM_ADDR, 14, SRAM word-address width (64 KiB).

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
req_vld  in  N_CLIENTS  per-client request valid
req_addr  in  N_CLIENTS*W_ADDR  per-client byte address, packed; client k occupies [k*W_ADDR +: W_ADDR]
req_size  in  N_CLIENTS*2  per-client size: 0 = byte, 1 = halfword, 2 = word
req_rdy  out  N_CLIENTS  one-cycle response strobe per client
req_data  out  W_DATA  response data, broadcast to all clients; valid only while some req_rdy bit is high
mem_ren  out  1  SRAM read request
mem_addr  out  W_MEM_ADDR  SRAM word address
mem_gnt  in  1  SRAM read accepted this cycle
mem_rdata  in  W_DATA  SRAM read data, valid the cycle after the mem_ren && mem_gnt edge
busy  out  1  high whenever state != IDLE
err  out  1  sticky; set by a bad request

Behaviour:
- Reset values: state IDLE, req_rdy=0, req_data=0, mem_ren=0, mem_addr=0, err=0, rr pointer = N_CLIENTS-1. Reset asserted mid-transaction abandons the transaction immediately; no rdy is issued afterwards.
- Client protocol:
  - Client holds vld, addr and size stable until its rdy pulse.
  - rdy is high for exactly one cycle; data is valid in that cycle.
  - A client may change its request on the rdy edge.
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
  - IDLE: if any req_vld bit is high, grant the first requesting index above the rr pointer, wrapping, and latch g, addr and size. The rr pointer becomes g.
  - IDLE to ISSUE for a legal request. IDLE to RESP with the error path for an illegal one.
  - ISSUE: mem_ren=1, mem_addr = addr[W_MEM_ADDR+1:2]; address bits above the word address are ignored.
    - mem_gnt=1 goes to CAPTURE.
    - req_vld[g]=0 with mem_gnt=0 (flush abort) goes back to IDLE with no rdy.
    - Otherwise stay in ISSUE.
  - CAPTURE: register the lane-replicated mem_rdata into req_data, then go to RESP. If req_vld[g] has dropped, go to IDLE instead and suppress the response.
  - RESP: req_rdy[g]=1 for this cycle only, then go to IDLE.
- Lane replication, with a = addr[1:0]:
  - Size 0: byte mem_rdata[8a +: 8], replicated 4 times.
  - Size 1: halfword mem_rdata[16*a[1] +: 16], replicated 2 times.
  - Size 2: the whole word.
- Latency: with no contention and mem_gnt=1, vld sampled high at edge 0 gives rdy high in the cycle after edge 3. That is one transaction per 4 cycles, and back-to-back grants are allowed.
- Illegal requests: size 3, a halfword with addr[0]=1, or a word with addr[1:0]!=0.
  - No SRAM access is made.
  - req_data=0, rdy is still pulsed in RESP, and err is set.
  - err stays set until rst.
- Fairness: with all clients requesting continuously, grants rotate 0,1,...,N-1,0. No client waits more than N-1 transactions.
- A stalled mem_gnt holds the FSM in ISSUE with mem_addr stable. Other clients' requests are ignored until the FSM returns to IDLE.

Decomposition:
- Shared package riscboy_ppu_pkg holds:
  - the size encodings (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2);
  - the FSM state localparams;
  - a lane-replicate function.
- One sub-module, riscboy_rr_arbiter (request vector in, one-hot grant out, rotating pointer, registered on an advance strobe). It is reusable by the sprite fetch unit.

Test Plan:
- Single client 0: word read at 0x4000 with mem[0x4000..0x4003]=11 22 33 44 -> req_data=0x44332211, req_rdy[0] in the cycle after edge 3, mem_addr=0x1000.
- Byte read at 0x4003, then halfword at 0x4002 on the same word -> 0x44444444, then 0x44334433.
- Both clients request continuously for 8 transactions, with the reset pointer -> grant order 0,1,0,1,...; never two consecutive rdy pulses to the same client.
- mem_gnt held low for 5 cycles -> FSM stays in ISSUE with mem_ren=1 and mem_addr stable; rdy arrives 3 cycles after gnt.
- Client drops vld during ISSUE (flush) -> no rdy, return to IDLE, next request served normally; drop during CAPTURE -> also no rdy.
- Halfword at 0x4001, and size=3 -> no mem_ren, rdy pulsed with data 0, err=1 persists until rst; rst asserted mid-ISSUE -> mem_ren=0 on the next cycle.
